// File: rtl/axi_eth_txarb_if.sv
// AXI-Stream link bundle shared by the two requester ports and the MAC port of
// axi_eth_txarb. master drives the payload and valid, slave drives ready.
interface axi_eth_txarb_if #(
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi_eth_txarb.sv
// Frame-granular arbiter sharing the MAC TX AXI-Stream between the DMA TX path
// (port 0) and the control-frame generator (port 1). A grant is held until the
// granted frame's tlast beat is accepted by the MAC, so frames never interleave.
// Also keeps per-port completed-frame counters and an oversize-frame monitor.
// Build option: define AXI_ETH_TXARB_PRIO_EN for strict priority to port 1;
// otherwise arbitration is round-robin.
module axi_eth_txarb #(
    parameter int unsigned C_DATA_W    = 64,
    parameter int unsigned C_CNT_W     = 16,
    parameter int unsigned C_MAX_BEATS = 1200
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    axi_eth_txarb_if.slave        s0_axis,
    axi_eth_txarb_if.slave        s1_axis,
    axi_eth_txarb_if.master       mac,
    output logic [1:0]            grant,
    output logic [C_CNT_W-1:0]    frm_cnt0,
    output logic [C_CNT_W-1:0]    frm_cnt1,
    output logic                  ovs_pulse,
    output logic                  ovs_sticky
);
    localparam int unsigned KEEP_W = C_DATA_W / 8;
    localparam int unsigned BEAT_W = $clog2(C_MAX_BEATS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic                rr_last_q;
    logic                rr_last_d;
    logic [BEAT_W-1:0]   beat_q;

    logic [C_DATA_W-1:0] sel_tdata_c;
    logic [KEEP_W-1:0]   sel_tkeep_c;
    logic                sel_tlast_c;
    logic                sel_tvalid_c;
    logic                hs_c;
    logic                done_c;

    // Route the granted port to the MAC and give it the MAC's ready
    always_comb begin
        sel_tdata_c    = '0;
        sel_tkeep_c    = '0;
        sel_tlast_c    = 1'b0;
        sel_tvalid_c   = 1'b0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
        case (state_q)
            ST_G0: begin
                sel_tdata_c    = s0_axis.tdata;
                sel_tkeep_c    = s0_axis.tkeep;
                sel_tlast_c    = s0_axis.tlast;
                sel_tvalid_c   = s0_axis.tvalid;
                s0_axis.tready = mac.tready;
            end
            ST_G1: begin
                sel_tdata_c    = s1_axis.tdata;
                sel_tkeep_c    = s1_axis.tkeep;
                sel_tlast_c    = s1_axis.tlast;
                sel_tvalid_c   = s1_axis.tvalid;
                s1_axis.tready = mac.tready;
            end
            default: ;
        endcase
        hs_c   = sel_tvalid_c & mac.tready;
        done_c = hs_c & sel_tlast_c;
    end

    assign mac.tdata  = sel_tdata_c;
    assign mac.tkeep  = sel_tkeep_c;
    assign mac.tlast  = sel_tlast_c;
    assign mac.tvalid = sel_tvalid_c;

    // Oversize: the handshake that brings the beat count to the limit without tlast
    assign ovs_pulse = hs_c & ~sel_tlast_c & (beat_q == BEAT_W'(C_MAX_BEATS - 1));

    // Next-state and round-robin bookkeeping; arbitration looks at tvalid only
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
`ifdef AXI_ETH_TXARB_PRIO_EN
                if (s1_axis.tvalid) begin
                    state_d = ST_G1;
                end else if (s0_axis.tvalid) begin
                    state_d = ST_G0;
                end
`else
                if (s0_axis.tvalid && s1_axis.tvalid) begin
                    state_d = rr_last_q ? ST_G0 : ST_G1;
                end else if (s0_axis.tvalid) begin
                    state_d = ST_G0;
                end else if (s1_axis.tvalid) begin
                    state_d = ST_G1;
                end
`endif
            end
            ST_G0: begin
                if (done_c) begin
                    state_d   = ST_IDLE;
                    rr_last_d = 1'b0;
                end
            end
            ST_G1: begin
                if (done_c) begin
                    state_d   = ST_IDLE;
                    rr_last_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and registered grant decode
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            grant     <= 2'b00;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            grant     <= {state_d == ST_G1, state_d == ST_G0};
        end
    end

    // Completed-frame counters, wrapping
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frm_cnt0 <= '0;
            frm_cnt1 <= '0;
        end else if (done_c) begin
            if (state_q == ST_G0) begin
                frm_cnt0 <= frm_cnt0 + C_CNT_W'(1);
            end else begin
                frm_cnt1 <= frm_cnt1 + C_CNT_W'(1);
            end
        end
    end

    // Beat counter: held at zero while idle so each grant starts fresh, saturates at the limit
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_q <= '0;
        end else if (state_q == ST_IDLE) begin
            beat_q <= '0;
        end else if (hs_c && (beat_q != BEAT_W'(C_MAX_BEATS))) begin
            beat_q <= beat_q + BEAT_W'(1);
        end
    end

    // Sticky oversize flag, cleared only by reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ovs_sticky <= 1'b0;
        end else if (ovs_pulse) begin
            ovs_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_eth_txarb.sv
// Directed bench for axi_eth_txarb built with C_MAX_BEATS=16. Sources replay
// queued frames whose data words carry {port, tag, beat}; every MAC handshake
// is compared against a hand-ordered list of expected beats.
module tb_axi_eth_txarb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  grant;
    logic [15:0] frm_cnt0;
    logic [15:0] frm_cnt1;
    logic        ovs_pulse;
    logic        ovs_sticky;

    always #5 clk = ~clk;

    axi_eth_txarb_if #(.DATA_W(64)) s0_if ();
    axi_eth_txarb_if #(.DATA_W(64)) s1_if ();
    axi_eth_txarb_if #(.DATA_W(64)) mac_if ();

    axi_eth_txarb #(
        .C_DATA_W    (64),
        .C_CNT_W     (16),
        .C_MAX_BEATS (16)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .s0_axis    (s0_if),
        .s1_axis    (s1_if),
        .mac        (mac_if),
        .grant      (grant),
        .frm_cnt0   (frm_cnt0),
        .frm_cnt1   (frm_cnt1),
        .ovs_pulse  (ovs_pulse),
        .ovs_sticky (ovs_sticky)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int          beat;
        int          port;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_tl = -1;
    int    npulse = 0;
    bit    gap_chk = 1'b0;
    bit    tog = 1'b0;
    int    q0_len[$];
    int    q0_tag[$];
    int    q1_len[$];
    int    q1_tag[$];
    int    b0 = 0;
    int    b1 = 0;
    bit    hs0 = 1'b0;
    bit    hs1 = 1'b0;
    beat_t exp_q[$];

    function automatic logic [63:0] mk(input int port, input int tag, input int beat);
        return {8'(port), 24'(tag), 32'(beat)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic src(input int port, input int len, input int tag);
        if (port == 0) begin
            q0_len.push_back(len);
            q0_tag.push_back(tag);
        end else begin
            q1_len.push_back(len);
            q1_tag.push_back(tag);
        end
    endtask

    task automatic expf(input int port, input int len, input int tag);
        beat_t e;
        for (int i = 0; i < len; i++) begin
            e.d    = mk(port, tag, i);
            e.l    = (i == len - 1);
            e.k    = e.l ? 8'h0F : 8'hFF;
            e.beat = i;
            e.port = port;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        if (q0_len.size() > 0) begin
            s0_if.tvalid = 1'b1;
            s0_if.tdata  = mk(0, q0_tag[0], b0);
            s0_if.tlast  = (b0 == q0_len[0] - 1);
            s0_if.tkeep  = s0_if.tlast ? 8'h0F : 8'hFF;
        end else begin
            s0_if.tvalid = 1'b0;
            s0_if.tdata  = '0;
            s0_if.tlast  = 1'b0;
            s0_if.tkeep  = '0;
        end
        if (q1_len.size() > 0) begin
            s1_if.tvalid = 1'b1;
            s1_if.tdata  = mk(1, q1_tag[0], b1);
            s1_if.tlast  = (b1 == q1_len[0] - 1);
            s1_if.tkeep  = s1_if.tlast ? 8'h0F : 8'hFF;
        end else begin
            s1_if.tvalid = 1'b0;
            s1_if.tdata  = '0;
            s1_if.tlast  = 1'b0;
            s1_if.tkeep  = '0;
        end
    endtask

    // One clock: advance sources after the edge, then sample and score at the falling edge
    task automatic step();
        beat_t e;
        logic  hs_m;
        @(posedge clk);
        #1;
        if (hs0) begin
            b0++;
            if (b0 == q0_len[0]) begin
                b0 = 0;
                void'(q0_len.pop_front());
                void'(q0_tag.pop_front());
            end
        end
        if (hs1) begin
            b1++;
            if (b1 == q1_len[0]) begin
                b1 = 0;
                void'(q1_len.pop_front());
                void'(q1_tag.pop_front());
            end
        end
        mac_if.tready = tog ? ~mac_if.tready : 1'b1;
        drive();
        @(negedge clk);
        cyc++;
        hs0  = s0_if.tvalid && s0_if.tready;
        hs1  = s1_if.tvalid && s1_if.tready;
        hs_m = mac_if.tvalid && mac_if.tready;
        check("s0_tready_excl", 64'(s0_if.tready && (grant != 2'b01)), 64'(0));
        check("s1_tready_excl", 64'(s1_if.tready && (grant != 2'b10)), 64'(0));
        if (hs_m) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(exp_q.size()), 64'(1));
            end else begin
                e = exp_q.pop_front();
                check("mac_tdata", mac_if.tdata, e.d);
                check("mac_tkeep", 64'(mac_if.tkeep), 64'(e.k));
                check("mac_tlast", 64'(mac_if.tlast), 64'(e.l));
                check("grant_beat", 64'(grant), (e.port == 1) ? 64'(2) : 64'(1));
                check("ovs_pulse", 64'(ovs_pulse), 64'((e.beat == 15) && !e.l));
                if (gap_chk && (e.beat == 0) && (last_tl >= 0)) begin
                    check("idle_gap", 64'(cyc - last_tl), 64'(2));
                end
                if (e.l) last_tl = cyc;
            end
        end else begin
            check("ovs_pulse_nohs", 64'(ovs_pulse), 64'(0));
        end
        if (ovs_pulse) npulse++;
    endtask

    task automatic run_until_empty(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() > 0) && (n < maxc)) begin
            step();
            n++;
        end
        check("frame_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        mac_if.tready = 1'b1;
        drive();
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_mac_tvalid", 64'(mac_if.tvalid), 64'(0));
        check("rst_s0_tready", 64'(s0_if.tready), 64'(0));
        check("rst_s1_tready", 64'(s1_if.tready), 64'(0));
        check("rst_cnt0", 64'(frm_cnt0), 64'(0));
        check("rst_cnt1", 64'(frm_cnt1), 64'(0));
        check("rst_ovs", 64'({ovs_pulse, ovs_sticky}), 64'(0));
        rst_n = 1'b1;
        step();
        step();

        // 10-beat frame from s0: grant one cycle after tvalid
        src(0, 10, 1);
        expf(0, 10, 1);
        drive();
        #1;
        check("t1_idle_grant", 64'(grant), 64'(0));
        check("t1_idle_mac_tvalid", 64'(mac_if.tvalid), 64'(0));
        check("t1_idle_s0_tready", 64'(s0_if.tready), 64'(0));
        step();
        check("t1_grant", 64'(grant), 64'(1));
        check("t1_mac_tvalid", 64'(mac_if.tvalid), 64'(1));
        run_until_empty(50);
        step();
        check("t1_grant_after", 64'(grant), 64'(0));
        check("t1_cnt0", 64'(frm_cnt0), 64'(1));
        check("t1_sticky", 64'(ovs_sticky), 64'(0));

        // 16-beat s1 frame with tlast exactly at the limit: no flag
        src(1, 16, 2);
        expf(1, 16, 2);
        run_until_empty(60);
        step();
        check("t2_cnt1", 64'(frm_cnt1), 64'(1));
        check("t2_sticky", 64'(ovs_sticky), 64'(0));
        check("t2_npulse", 64'(npulse), 64'(0));

        // 20-beat s1 frame: one pulse on the 16th handshake, frame still delivered
        src(1, 20, 3);
        expf(1, 20, 3);
        run_until_empty(60);
        step();
        check("t3_cnt1", 64'(frm_cnt1), 64'(2));
        check("t3_sticky", 64'(ovs_sticky), 64'(1));
        check("t3_npulse", 64'(npulse), 64'(1));

        // Both ports continuously valid, lengths 23 and 11
        gap_chk = 1'b1;
        last_tl = -1;
        src(0, 23, 10);
        src(0, 23, 12);
        src(1, 11, 11);
        src(1, 11, 13);
`ifdef AXI_ETH_TXARB_PRIO_EN
        expf(1, 11, 11);
        expf(1, 11, 13);
        expf(0, 23, 10);
        expf(0, 23, 12);
`else
        expf(0, 23, 10);
        expf(1, 11, 11);
        expf(0, 23, 12);
        expf(1, 11, 13);
`endif
        drive();
        run_until_empty(200);
        step();
        gap_chk = 1'b0;
        check("t4_cnt0", 64'(frm_cnt0), 64'(3));
        check("t4_cnt1", 64'(frm_cnt1), 64'(4));
        check("t4_npulse", 64'(npulse), 64'(3));

        // 30-beat s0 frame with mac_tready toggling every cycle
        tog = 1'b1;
        src(0, 30, 20);
        expf(0, 30, 20);
        drive();
        run_until_empty(200);
        tog = 1'b0;
        step();
        check("t5_cnt0", 64'(frm_cnt0), 64'(4));
        check("t5_npulse", 64'(npulse), 64'(4));

        // Reset while beat 5 of a 40-beat frame is on the bus
        src(0, 40, 30);
        expf(0, 40, 30);
        drive();
        for (int i = 0; i < 100 && exp_q.size() > 35; i++) step();
        check("t6_pre_tvalid", 64'(mac_if.tvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t6_mac_tvalid", 64'(mac_if.tvalid), 64'(0));
        check("t6_grant", 64'(grant), 64'(0));
        check("t6_cnt0", 64'(frm_cnt0), 64'(0));
        check("t6_cnt1", 64'(frm_cnt1), 64'(0));
        check("t6_sticky", 64'(ovs_sticky), 64'(0));
        q0_len.delete();
        q0_tag.delete();
        exp_q.delete();
        b0 = 0;
        hs0 = 1'b0;
        hs1 = 1'b0;
        drive();
        step();
        step();
        rst_n = 1'b1;
        step();
        src(0, 12, 40);
        expf(0, 12, 40);
        drive();
        step();
        check("t6_regrant", 64'(grant), 64'(1));
        run_until_empty(60);
        step();
        check("t6_cnt0_after", 64'(frm_cnt0), 64'(1));
        check("t6_grant_after", 64'(grant), 64'(0));
        check("t6_sticky_after", 64'(ovs_sticky), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
